// File: rtl/alu_issue_pkg.sv
// Shared constants, FSM encoding and decoded-record type for the ALU issue block.
// Optional overflow exceptions are enabled with the ALU_ISSUE_OVF_EXC_EN macro.
package alu_issue_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  localparam int RSTATUS_REG_DEF = 30;
  localparam int EXC_ADD_DEF     = 1;
  localparam int EXC_ADDI_DEF    = 2;
  localparam int EXC_SUB_DEF     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_OTHER = 3'd0,
    K_RTYPE = 3'd1,
    K_ADDI  = 3'd2,
    K_BNE   = 3'd3,
    K_BLT   = 3'd4
  } kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [4:0]  alu_op;
    logic [4:0]  shamt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        wren;
  } dec_t;

  function automatic logic [31:0] sext17(input logic [16:0] imm);
    return {{15{imm[16]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of an instruction word and its register-file reads
// into ALU controls, operands and writeback metadata.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] insn,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output dec_t        dec
);

  logic unused_bits;
  assign unused_bits = &{1'b0, insn[1:0]};

  always_comb begin
    dec = '0;
    dec.kind = K_OTHER;
    unique case (insn[31:27])
      OP_RTYPE: begin
        dec.kind   = K_RTYPE;
        dec.alu_op = insn[6:2];
        dec.shamt  = insn[11:7];
        dec.op_a   = rs;
        dec.op_b   = rt;
        dec.rd     = insn[26:22];
        dec.wren   = 1'b1;
      end
      OP_ADDI: begin
        dec.kind   = K_ADDI;
        dec.alu_op = ALU_ADD;
        dec.op_a   = rs;
        dec.op_b   = sext17(insn[16:0]);
        dec.rd     = insn[26:22];
        dec.wren   = 1'b1;
      end
      // Branches compare $rd (second read port) against $rs.
      OP_BNE, OP_BLT: begin
        dec.kind   = (insn[31:27] == OP_BNE) ? K_BNE : K_BLT;
        dec.alu_op = ALU_SUB;
        dec.op_a   = rt;
        dec.op_b   = rs;
        dec.rd     = insn[26:22];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/driver side of the combinational ALU: handshake in, registered ALU
// inputs, captured result record out. Overflow exceptions: ALU_ISSUE_OVF_EXC_EN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int RSTATUS_REG = RSTATUS_REG_DEF,
  parameter int EXC_ADD     = EXC_ADD_DEF,
  parameter int EXC_ADDI    = EXC_ADDI_DEF,
  parameter int EXC_SUB     = EXC_SUB_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic [4:0]  ctrl_ALUopcode,
  output logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        isNotEqual,
  input  logic        isLessThan,
  input  logic        overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wren,
  output logic        out_branch_taken,
  output logic        out_exception
);

  state_t      state_reg;
  kind_t       kind_reg;
  logic [4:0]  rd_reg;
  logic        wren_reg;
  dec_t        dec;
  logic        accept;

  logic [31:0] rec_data;
  logic [4:0]  rec_rd;
  logic        rec_wren;
  logic        rec_taken;
  logic        rec_exc;

  alu_issue_decode u_decode (
    .insn (in_insn),
    .rs   (in_rs),
    .rt   (in_rt),
    .dec  (dec)
  );

  assign in_ready = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    rec_data  = data_result;
    rec_rd    = rd_reg;
    rec_wren  = wren_reg;
    rec_exc   = 1'b0;
    rec_taken = ((kind_reg == K_BNE) & isNotEqual) | ((kind_reg == K_BLT) & isLessThan);
`ifdef ALU_ISSUE_OVF_EXC_EN
    if (overflow) begin
      if (kind_reg == K_ADDI) begin
        rec_exc  = 1'b1;
        rec_data = 32'(EXC_ADDI);
      end else if (kind_reg == K_RTYPE && ctrl_ALUopcode == ALU_ADD) begin
        rec_exc  = 1'b1;
        rec_data = 32'(EXC_ADD);
      end else if (kind_reg == K_RTYPE && ctrl_ALUopcode == ALU_SUB) begin
        rec_exc  = 1'b1;
        rec_data = 32'(EXC_SUB);
      end
      if (rec_exc) begin
        rec_rd   = 5'(RSTATUS_REG);
        rec_wren = 1'b1;
      end
    end
`endif
  end

`ifndef ALU_ISSUE_OVF_EXC_EN
  // Without the exception feature the overflow flag has no effect.
  logic unused_ovf;
  assign unused_ovf = &{1'b0, overflow};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      kind_reg         <= K_OTHER;
      rd_reg           <= '0;
      wren_reg         <= 1'b0;
      ctrl_ALUopcode   <= '0;
      ctrl_shiftamt    <= '0;
      data_operandA    <= '0;
      data_operandB    <= '0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_rd           <= '0;
      out_wren         <= 1'b0;
      out_branch_taken <= 1'b0;
      out_exception    <= 1'b0;
    end else begin
      // ALU-facing registers move only on an accepted record.
      if (accept) begin
        kind_reg       <= dec.kind;
        rd_reg         <= dec.rd;
        wren_reg       <= dec.wren;
        ctrl_ALUopcode <= dec.alu_op;
        ctrl_shiftamt  <= dec.shamt;
        data_operandA  <= dec.op_a;
        data_operandB  <= dec.op_b;
      end
      unique case (state_reg)
        ST_IDLE: begin
          if (accept) state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          out_data         <= rec_data;
          out_rd           <= rec_rd;
          out_wren         <= rec_wren;
          out_branch_taken <= rec_taken;
          out_exception    <= rec_exc;
          out_valid        <= 1'b1;
          state_reg        <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue with a small behavioural ALU on the
// other side of the interface.
module tb_alu_issue;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_insn, in_rs, in_rt;
  logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        isNotEqual, isLessThan, overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wren, out_branch_taken, out_exception;

  int checks = 0;
  int errors = 0;

  alu_issue dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_rs(in_rs), .in_rt(in_rt),
    .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .isNotEqual(isNotEqual),
    .isLessThan(isLessThan), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_wren(out_wren),
    .out_branch_taken(out_branch_taken), .out_exception(out_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: 0 add, 1 sub, 4 sll, otherwise and.
  always_comb begin
    overflow = 1'b0;
    unique case (ctrl_ALUopcode)
      5'd0: begin
        data_result = data_operandA + data_operandB;
        overflow = (data_operandA[31] == data_operandB[31]) && (data_result[31] != data_operandA[31]);
      end
      5'd1: begin
        data_result = data_operandA - data_operandB;
        overflow = (data_operandA[31] != data_operandB[31]) && (data_result[31] != data_operandA[31]);
      end
      5'd4:    data_result = data_operandA << ctrl_shiftamt;
      default: data_result = data_operandA & data_operandB;
    endcase
    isNotEqual = (data_operandA != data_operandB);
    isLessThan = ($signed(data_operandA) < $signed(data_operandB));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one record, waits (bounded) for in_ready, and returns just after the accepting edge.
  task automatic accept(input string name, input logic [31:0] insn, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    in_insn  = insn;
    in_rs    = rs;
    in_rt    = rt;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("txn %s: insn=%h rs=%h rt=%h accepted", name, insn, rs, rt);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] sh,
                                        input logic [4:0] op);
    return {5'b00000, rd, rs, rt, sh, op, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {opc, rd, rs, imm};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_insn = '0; in_rs = '0; in_rt = '0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_aluop", {27'd0, ctrl_ALUopcode}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // addi $3,$1,-5 with rs=10
    accept("addi", itype(5'b00101, 5'd3, 5'd1, 17'h1FFFB), 32'd10, 32'd0);
    check("addi_aluop", {27'd0, ctrl_ALUopcode}, 32'd0);
    check("addi_opA", data_operandA, 32'd10);
    check("addi_opB", data_operandB, 32'hFFFFFFFB);
    check("addi_valid_k1", {31'd0, out_valid}, 32'd0);
    tick();
    check("addi_valid_k2", {31'd0, out_valid}, 32'd1);
    check("addi_data", out_data, 32'd5);
    check("addi_rd", {27'd0, out_rd}, 32'd3);
    check("addi_wren", {31'd0, out_wren}, 32'd1);
    check("addi_exc", {31'd0, out_exception}, 32'd0);
    release_out();
    check("addi_released", {31'd0, out_valid}, 32'd0);
    check("addi_idle_ready", {31'd0, in_ready}, 32'd1);

    // R-type add overflowing
    accept("add_ovf", rtype(5'd5, 5'd1, 5'd2, 5'd0, 5'd0), 32'h7FFFFFFF, 32'd1);
    tick();
`ifdef ALU_ISSUE_OVF_EXC_EN
    check("add_ovf_data", out_data, 32'd1);
    check("add_ovf_rd", {27'd0, out_rd}, 32'd30);
    check("add_ovf_exc", {31'd0, out_exception}, 32'd1);
`else
    check("add_ovf_data", out_data, 32'h80000000);
    check("add_ovf_rd", {27'd0, out_rd}, 32'd5);
    check("add_ovf_exc", {31'd0, out_exception}, 32'd0);
`endif
    check("add_ovf_wren", {31'd0, out_wren}, 32'd1);
    release_out();

    // R-type sll with shift amount 3
    accept("sll", rtype(5'd6, 5'd1, 5'd2, 5'd3, 5'd4), 32'd5, 32'd99);
    check("sll_shamt", {27'd0, ctrl_shiftamt}, 32'd3);
    check("sll_aluop", {27'd0, ctrl_ALUopcode}, 32'd4);
    tick();
    check("sll_data", out_data, 32'd40);
    check("sll_rd", {27'd0, out_rd}, 32'd6);
    release_out();

    // bne equal operands: not taken
    accept("bne", itype(5'b00010, 5'd4, 5'd1, 17'd8), 32'd4, 32'd4);
    check("bne_aluop", {27'd0, ctrl_ALUopcode}, 32'd1);
    check("bne_shamt", {27'd0, ctrl_shiftamt}, 32'd0);
    tick();
    check("bne_taken", {31'd0, out_branch_taken}, 32'd0);
    check("bne_wren", {31'd0, out_wren}, 32'd0);
    release_out();

    // blt $rd=-1 < $rs=2: taken
    accept("blt", itype(5'b00110, 5'd4, 5'd1, 17'd8), 32'd2, 32'hFFFFFFFF);
    check("blt_opA", data_operandA, 32'hFFFFFFFF);
    check("blt_opB", data_operandB, 32'd2);
    tick();
    check("blt_taken", {31'd0, out_branch_taken}, 32'd1);
    check("blt_wren", {31'd0, out_wren}, 32'd0);
    release_out();

    // Unknown opcode
    accept("op1f", 32'hF8000000 | 32'h0001_2345, 32'd7, 32'd9);
    tick();
    check("op1f_valid", {31'd0, out_valid}, 32'd1);
    check("op1f_wren", {31'd0, out_wren}, 32'd0);
    check("op1f_taken", {31'd0, out_branch_taken}, 32'd0);
    check("op1f_exc", {31'd0, out_exception}, 32'd0);
    release_out();

    // Backpressure then back-to-back accept
    accept("sub_bp", rtype(5'd7, 5'd1, 5'd2, 5'd0, 5'd1), 32'd20, 32'd6);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'd14);
      check("bp_rd", {27'd0, out_rd}, 32'd7);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_insn   = rtype(5'd8, 5'd3, 5'd4, 5'd0, 5'd0);
    in_rs     = 32'd100;
    in_rt     = 32'd23;
    #1;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    $display("txn b2b_add: accepted while releasing previous record");
    check("b2b_valid_k1", {31'd0, out_valid}, 32'd0);
    check("b2b_opA", data_operandA, 32'd100);
    tick();
    check("b2b_valid_k2", {31'd0, out_valid}, 32'd1);
    check("b2b_data", out_data, 32'd123);
    check("b2b_rd", {27'd0, out_rd}, 32'd8);
    release_out();

    // Asynchronous reset during EXEC
    accept("rst_exec", rtype(5'd9, 5'd1, 5'd2, 5'd0, 5'd1), 32'd50, 32'd8);
    check("rst_exec_aluop_pre", {27'd0, ctrl_ALUopcode}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_exec_valid", {31'd0, out_valid}, 32'd0);
    check("rst_exec_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_exec_aluop", {27'd0, ctrl_ALUopcode}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
